// File: rtl/mmu_arbiter_if.sv
// mmu_arbiter_if: bundles both requester ports and the mmu-side bus.
//   pN_*   : requester request fields (read/write enables, signedness, width,
//            address, write data) and responses (data_out, mem_ready, error).
//   mmu_*  : registered request toward the mmu, plus its data_out/mem_ready.
// Modports: slave = arbiter view, master = the requesters + mmu (bench) view.
interface mmu_arbiter_if;
  logic        p0_read_enable,  p1_read_enable;
  logic        p0_write_enable, p1_write_enable;
  logic        p0_mem_signed_read, p1_mem_signed_read;
  logic [1:0]  p0_mem_data_width,  p1_mem_data_width;
  logic [31:0] p0_address, p1_address;
  logic [31:0] p0_data_in, p1_data_in;
  logic [31:0] p0_data_out, p1_data_out;
  logic        p0_mem_ready, p1_mem_ready;
  logic        p0_error, p1_error;

  logic        mmu_read_enable;
  logic        mmu_write_enable;
  logic        mmu_mem_signed_read;
  logic [1:0]  mmu_mem_data_width;
  logic [31:0] mmu_address;
  logic [31:0] mmu_data_in;
  logic [31:0] mmu_data_out;
  logic        mmu_mem_ready;

  modport slave (
    input  p0_read_enable, p1_read_enable, p0_write_enable, p1_write_enable,
           p0_mem_signed_read, p1_mem_signed_read, p0_mem_data_width,
           p1_mem_data_width, p0_address, p1_address, p0_data_in, p1_data_in,
           mmu_data_out, mmu_mem_ready,
    output p0_data_out, p1_data_out, p0_mem_ready, p1_mem_ready,
           p0_error, p1_error,
           mmu_read_enable, mmu_write_enable, mmu_mem_signed_read,
           mmu_mem_data_width, mmu_address, mmu_data_in
  );

  modport master (
    output p0_read_enable, p1_read_enable, p0_write_enable, p1_write_enable,
           p0_mem_signed_read, p1_mem_signed_read, p0_mem_data_width,
           p1_mem_data_width, p0_address, p1_address, p0_data_in, p1_data_in,
           mmu_data_out, mmu_mem_ready,
    input  p0_data_out, p1_data_out, p0_mem_ready, p1_mem_ready,
           p0_error, p1_error,
           mmu_read_enable, mmu_write_enable, mmu_mem_signed_read,
           mmu_mem_data_width, mmu_address, mmu_data_in
  );
endinterface

// File: rtl/mmu_arbiter.sv
// mmu_arbiter: shares one mmu port between instruction fetch (port 0) and
// load/store (port 1). The winning request is latched into registered mmu_*
// outputs, held until mmu_mem_ready (or timeout), and answered with a
// one-cycle ready pulse on the granted port.
//   clk, reset_n : clock, async active-low reset
//   bus          : mmu_arbiter_if.slave (requester ports + mmu bus)
//   busy         : high whenever the arbiter is not IDLE

// Per-port response registers: ready/error pulse and sticky read data.
module mmu_arb_port (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpl,       // transaction for this port ends this cycle
  input  logic        cpl_rd,    // it was a read
  input  logic        cpl_to,    // it ended by timeout
  input  logic [31:0] cpl_data,
  output logic [31:0] data_out,
  output logic        mem_ready,
  output logic        error
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out  <= '0;
      mem_ready <= 1'b0;
      error     <= 1'b0;
    end else begin
      mem_ready <= cpl;
      error     <= cpl & cpl_to;
      // Timed-out transactions return zero; writes leave the last read data.
      if (cpl && cpl_to)      data_out <= '0;
      else if (cpl && cpl_rd) data_out <= cpl_data;
    end
  end
endmodule

module mmu_arbiter #(
  parameter int RR_ENABLE      = 1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  mmu_arbiter_if.slave bus,
  output logic         busy
);
  localparam int NUM_PORTS = 2;
  localparam bit TO_EN     = (TIMEOUT_CYCLES != 0);
  // Counter holds completed ISSUE cycles, so the abort fires in the
  // TIMEOUT_CYCLES-th ISSUE cycle.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t state;
  logic   last_grant, grant, sel;
  logic [15:0] cnt;

  logic [NUM_PORTS-1:0]       rd_en, wr_en, sgn, req;
  logic [NUM_PORTS-1:0][1:0]  width;
  logic [NUM_PORTS-1:0][31:0] addr, wdata;
  logic [NUM_PORTS-1:0]       cpl, p_rdy, p_err;
  logic [NUM_PORTS-1:0][31:0] p_data;

  logic mmu_rd, mmu_wr, mmu_sgn;
  logic [1:0]  mmu_width;
  logic [31:0] mmu_addr, mmu_wdata;
  logic ack, tmo;

  assign rd_en = {bus.p1_read_enable,     bus.p0_read_enable};
  assign wr_en = {bus.p1_write_enable,    bus.p0_write_enable};
  assign sgn   = {bus.p1_mem_signed_read, bus.p0_mem_signed_read};
  assign width = {bus.p1_mem_data_width,  bus.p0_mem_data_width};
  assign addr  = {bus.p1_address,         bus.p0_address};
  assign wdata = {bus.p1_data_in,         bus.p0_data_in};
  assign req   = rd_en | wr_en;

  always_comb begin
    sel = 1'b0;
    if (req[0] && req[1]) sel = (RR_ENABLE != 0) ? ~last_grant : 1'b0;
    else                  sel = req[1];
  end

  // Stale mmu_mem_ready outside ISSUE is ignored by construction.
  assign ack = (state == ISSUE) && bus.mmu_mem_ready;
  assign tmo = TO_EN && (state == ISSUE) && !bus.mmu_mem_ready && (cnt == TO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      cnt        <= '0;
      mmu_rd     <= 1'b0;
      mmu_wr     <= 1'b0;
      mmu_sgn    <= 1'b0;
      mmu_width  <= '0;
      mmu_addr   <= '0;
      mmu_wdata  <= '0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          grant      <= sel;
          last_grant <= sel;
          // Read+write together is a write: suppress the read side.
          mmu_rd     <= rd_en[sel] & ~wr_en[sel];
          mmu_wr     <= wr_en[sel];
          mmu_sgn    <= sgn[sel] & ~wr_en[sel];
          mmu_width  <= width[sel];
          mmu_addr   <= addr[sel];
          mmu_wdata  <= wdata[sel];
          cnt        <= '0;
          state      <= ISSUE;
        end
        ISSUE: begin
          if (ack || tmo) begin
            mmu_rd <= 1'b0;
            mmu_wr <= 1'b0;
            state  <= DONE;
          end else if (cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign cpl[i] = (ack || tmo) && (grant == i[0]);
    mmu_arb_port u_port (
      .clk      (clk),
      .reset_n  (reset_n),
      .cpl      (cpl[i]),
      .cpl_rd   (mmu_rd),
      .cpl_to   (tmo),
      .cpl_data (bus.mmu_data_out),
      .data_out (p_data[i]),
      .mem_ready(p_rdy[i]),
      .error    (p_err[i])
    );
  end

  assign bus.p0_data_out  = p_data[0];
  assign bus.p1_data_out  = p_data[1];
  assign bus.p0_mem_ready = p_rdy[0];
  assign bus.p1_mem_ready = p_rdy[1];
  assign bus.p0_error     = p_err[0];
  assign bus.p1_error     = p_err[1];

  assign bus.mmu_read_enable     = mmu_rd;
  assign bus.mmu_write_enable    = mmu_wr;
  assign bus.mmu_mem_signed_read = mmu_sgn;
  assign bus.mmu_mem_data_width  = mmu_width;
  assign bus.mmu_address         = mmu_addr;
  assign bus.mmu_data_in         = mmu_wdata;

  assign busy = (state != IDLE);
endmodule
